// File: rtl/afifo_rd_stream.sv
// afifo_rd_stream: drains the async FIFO read port into a 2-entry registered valid/ready stream buffer
module afifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk_rd,
  input  logic                  rst_rd_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            buf_cnt,
  output logic [CNT_WIDTH-1:0]  word_cnt
);
  logic [DATA_WIDTH-1:0] mem [2];
  logic head, tail, inflight, pop, cap;
  logic [2:0] occ;
  always_comb begin
    pop = m_valid & m_ready;
    cap = inflight & ~flush;
    occ = {1'b0, buf_cnt} + {2'b0, inflight};
    fifo_rd_en = ~fifo_empty & ~flush & ((occ < 3'd2) | pop);
  end
  assign m_valid = buf_cnt != 2'd0;
  assign m_data = mem[head];
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head <= 1'b0;
      tail <= 1'b0;
      inflight <= 1'b0;
      buf_cnt <= 2'd0;
      word_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      word_cnt <= word_cnt + CNT_WIDTH'(pop);
      if (flush) begin
        head <= 1'b0;
        tail <= 1'b0;
        buf_cnt <= 2'd0;
      end else begin
        if (cap) mem[tail] <= fifo_rdata;
        tail <= tail ^ cap;
        head <= head ^ pop;
        buf_cnt <= buf_cnt + 2'(cap) - 2'(pop);
      end
    end
  end
  assert property (@(posedge clk_rd) disable iff (!rst_rd_n)
    occ <= 3'd2 && !(cap && buf_cnt == 2'd2 && !pop));
endmodule

// File: doc/afifo_rd_stream.md
# afifo_rd_stream

Read-side drain controller for the asynchronous FIFO. It lives entirely in the read clock domain. It issues read strobes to the FIFO read port and absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer. It presents the data downstream as a valid/ready stream with full throughput and no combinational path from `m_ready` to `m_data`/`m_valid`.

## Interface
- `DATA_WIDTH`, default 32: width of FIFO read data and stream data.
- `CNT_WIDTH`, default 16: width of the delivered-word counter.

Ports (clock and reset first):
- `clk_rd` input 1: read-domain clock. One clock; all logic is on its rising edge.
- `rst_rd_n` input 1: asynchronous, active-low reset. Shared with the FIFO read side.
- `fifo_empty` input 1: FIFO read-side empty flag, already synchronised to `clk_rd`.
- `fifo_rd_en` output 1: read strobe to the FIFO. Combinational.
- `fifo_rdata` input DATA_WIDTH: FIFO read data. Valid exactly one cycle after a `fifo_rd_en` cycle.
- `flush` input 1: synchronous flush. Drops buffered and in-flight data.
- `m_valid` output 1: stream data valid. Registered.
- `m_ready` input 1: downstream accept.
- `m_data` output DATA_WIDTH: stream data. Registered, driven from the buffer head.
- `buf_cnt` output 2: number of words held in the output buffer (0..2).
- `word_cnt` output CNT_WIDTH: number of words delivered (pops), wrapping.

## Operation
- Definitions:
  - pop = `m_valid & m_ready`.
  - `inflight` = registered copy of `fifo_rd_en` (1 bit).
  - occ = `buf_cnt` + `inflight` (0..3 arithmetic, must never exceed 2).
- Read issue: `fifo_rd_en = ~fifo_empty & ~flush & ((occ < 2) | pop)`.
  - Never asserted while `fifo_empty` is high.
  - Never asserted in a flush cycle.
- Capture: when `inflight` is 1 and `flush` is 0, `fifo_rdata` is written into the buffer tail at the end of that cycle.
- Buffer:
  - 2-entry, in-order circular buffer with 1-bit head and tail pointers that wrap 1 -> 0.
  - `m_valid = (buf_cnt != 0)`; `m_data` = head entry.
- Simultaneous capture and pop: `buf_cnt` is unchanged, head advances, tail advances.
- Stream rules:
  - While `m_valid` is 1 and `m_ready` is 0, `m_valid` and `m_data` hold stable.
  - No bubble is inserted while the FIFO is non-empty and `m_ready` is held high.
- `word_cnt` increments by 1 on every pop and wraps all-ones -> 0. It is not cleared by `flush`.
- Flush (1-cycle pulse or level):
  - In the flush cycle, the buffer is cleared and `buf_cnt` <- 0 at the clock edge.
  - Data arriving on `fifo_rdata` in the flush cycle (from a read issued the previous cycle) is discarded.
  - `inflight` <- 0, because `fifo_rd_en` is 0 during flush.
  - A pop occurring in the flush cycle still counts in `word_cnt`.
  - Flush has priority over capture and pop for buffer state.
- Reset (asynchronous, any time, including mid-burst):
  - `buf_cnt`=0, `m_valid`=0, `m_data`=0, `word_cnt`=0, `inflight`=0, pointers=0.
  - `fifo_rd_en` = `~fifo_empty`. The FIFO read side is held in reset by the same `rst_rd_n`, so no read takes effect.

## Timing
- Read latency:
  - `fifo_rd_en` high in cycle T -> word captured at the end of T+1.
  - `m_valid`=1 with that word in cycle T+2 (2-cycle FIFO-to-stream latency).
- Throughput: 1 word/cycle sustained. In steady state with `m_ready`=1, `buf_cnt`=1 and `inflight`=1.
- Backpressure:
  - `m_ready` low -> at most 2 words are buffered.
  - `fifo_rd_en` drops to 0 once occ=2.
  - The first cycle `m_ready` returns high, `fifo_rd_en` may reassert in that same cycle (pop term).
- `buf_cnt` and `word_cnt` reflect state after the previous edge. Both are registered.
- Invariant (checked by SVA): occ <= 2 in every cycle; capture never occurs when `buf_cnt`=2 without a simultaneous pop.

## Test plan
- Reset, then FIFO preloaded with 0xA0..0xA3, `m_ready`=1:
  - `fifo_rd_en` high from cycle 0.
  - `m_valid` first high in cycle 2 with 0xA0.
  - 4 consecutive words, no bubbles.
  - `word_cnt`=4.
- `m_ready`=0 with 8 words available:
  - Exactly 2 reads are issued; `buf_cnt`=2.
  - `m_data`=first word, held stable for 10 cycles.
  - Releasing `m_ready` delivers the words in order.
- Alternating `m_ready` 1/0 over 16 words (0x00..0x0F): all 16 delivered in order, none duplicated; `word_cnt`=16.
- Flush asserted 1 cycle after a read issue, with `buf_cnt`=1:
  - Next cycle `m_valid`=0 and `buf_cnt`=0.
  - The in-flight word is dropped.
  - The next delivered word is the FIFO's following entry.
- `fifo_empty` toggling every cycle: `fifo_rd_en` is never high while `fifo_empty`=1; occ never exceeds 2.
- `word_cnt` preloaded to 0xFFFE via 65534 pops, then 3 pops: `word_cnt` reads 0xFFFF, 0x0000, 0x0001. Asynchronous reset mid-stream zeroes all outputs within the same cycle.
